mtr_ramp_ctrl: RTL

Slew-rate controller that sequences the left/right motor drive. Accepts target wheel speeds over a valid/ready command interface. Ramps the signed 11-bit lft_speed/rght_speed outputs toward those targets in bounded steps, and forces a fast ramp to zero on emergency stop. Its outputs feed the motor PWM driver directly; a speed of 0 there means 50% duty.

---
 rtl/mtr_ctrl_pkg.sv | 25 ++
 rtl/spd_slew.sv | 40 ++++
 rtl/mtr_ramp_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mtr_ctrl_pkg.sv
// Shared types and speed limits for the motor ramp controller.
// Speeds are signed 11-bit, kept symmetric about zero.
package mtr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RAMP,
        BRAKE
    } state_t;

    localparam logic signed [10:0] SPD_MAX = 11'sd1023;
    localparam logic signed [10:0] SPD_MIN = -11'sd1023;

    // Only -1024 actually needs clamping; it keeps the range symmetric.
    function automatic logic signed [10:0] sat_spd(input logic signed [10:0] v);
        if (v < SPD_MIN) begin
            return SPD_MIN;
        end else if (v > SPD_MAX) begin
            return SPD_MAX;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/spd_slew.sv
// One wheel's speed register.
// It moves toward its target by at most step_size whenever step_en is high.
module spd_slew (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] tgt,
    input  logic        step_en,
    input  logic [10:0] step_size,
    output logic [10:0] cur,
    output logic [10:0] cur_nxt
);

    logic [11:0] diff;
    logic [11:0] mag;
    logic [10:0] stepped;

    // The difference is taken in 12 bits so that the full -2046..+2046 span is representable.
    always_comb begin
        diff    = {tgt[10], tgt} - {cur[10], cur};
        mag     = diff[11] ? (12'd0 - diff) : diff;
        stepped = diff[11] ? (cur - step_size) : (cur + step_size);
        cur_nxt = cur;
        if (step_en) begin
            if (mag <= {1'b0, step_size}) begin
                cur_nxt = tgt;
            end else begin
                cur_nxt = stepped;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= '0;
        end else begin
            cur <= cur_nxt;
        end
    end

endmodule

// File: rtl/mtr_ramp_ctrl.sv
// Slew-rate controller for the left/right motor drive.
// It ramps both speeds toward the commanded targets, and estop brakes both speeds to zero.
module mtr_ramp_ctrl
    import mtr_ctrl_pkg::*;
#(
    parameter int RAMP_DIV   = 1024,
    parameter int STEP       = 8,
    parameter int BRAKE_STEP = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_vld,
    output logic        cmd_rdy,
    input  logic [10:0] lft_tgt,
    input  logic [10:0] rght_tgt,
    input  logic        estop,
    output logic [10:0] lft_speed,
    output logic [10:0] rght_speed,
    output logic        busy,
    output logic        ramp_done
);

    localparam int               CNT_W        = $clog2(RAMP_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(RAMP_DIV - 1);
    localparam logic [10:0]      STEP_W       = 11'(STEP);
    localparam logic [10:0]      BRAKE_STEP_W = 11'(BRAKE_STEP);

    state_t           state;
    logic [10:0]      lft_tgt_q;
    logic [10:0]      rght_tgt_q;
    logic [10:0]      lft_nxt;
    logic [10:0]      rght_nxt;
    logic [10:0]      step_size;
    logic [CNT_W-1:0] tick_cnt;
    logic [CNT_W-1:0] tick_inc;
    logic             accept;
    logic             step_en;
    logic             at_tgt;
    logic             at_zero;

    assign cmd_rdy   = ~estop & (state != BRAKE);
    assign accept    = cmd_vld & cmd_rdy;
    assign busy      = (state != IDLE);
    assign step_en   = busy && (tick_cnt == CNT_LAST);
    assign step_size = (state == BRAKE) ? BRAKE_STEP_W : STEP_W;
    assign tick_inc  = (tick_cnt == CNT_LAST) ? '0 : tick_cnt + 1'b1;

    // Completion looks at post-step speeds, so IDLE follows the final step edge directly.
    assign at_tgt  = (lft_nxt == lft_tgt_q) && (rght_nxt == rght_tgt_q);
    assign at_zero = (lft_nxt == '0) && (rght_nxt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lft_tgt_q  <= '0;
            rght_tgt_q <= '0;
            tick_cnt   <= '0;
            ramp_done  <= 1'b0;
        end else begin
            ramp_done <= 1'b0;
            if (estop) begin
                if (state != BRAKE) begin
                    state      <= BRAKE;
                    lft_tgt_q  <= '0;
                    rght_tgt_q <= '0;
                    tick_cnt   <= '0;
                end else begin
                    tick_cnt <= tick_inc;
                end
            end else begin
                case (state)
                    IDLE: begin
                        tick_cnt <= '0;
                        if (accept) begin
                            lft_tgt_q  <= sat_spd($signed(lft_tgt));
                            rght_tgt_q <= sat_spd($signed(rght_tgt));
                            state      <= RAMP;
                        end
                    end
                    RAMP: begin
                        if (accept) begin
                            lft_tgt_q  <= sat_spd($signed(lft_tgt));
                            rght_tgt_q <= sat_spd($signed(rght_tgt));
                            tick_cnt   <= '0;
                        end else if (at_tgt) begin
                            state     <= IDLE;
                            ramp_done <= 1'b1;
                            tick_cnt  <= '0;
                        end else begin
                            tick_cnt <= tick_inc;
                        end
                    end
                    BRAKE: begin
                        if (at_zero) begin
                            state    <= IDLE;
                            tick_cnt <= '0;
                        end else begin
                            tick_cnt <= tick_inc;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        tick_cnt <= '0;
                    end
                endcase
            end
        end
    end

    spd_slew u_lft (
        .clk       (clk),
        .rst       (rst),
        .tgt       (lft_tgt_q),
        .step_en   (step_en),
        .step_size (step_size),
        .cur       (lft_speed),
        .cur_nxt   (lft_nxt)
    );

    spd_slew u_rght (
        .clk       (clk),
        .rst       (rst),
        .tgt       (rght_tgt_q),
        .step_en   (step_en),
        .step_size (step_size),
        .cur       (rght_speed),
        .cur_nxt   (rght_nxt)
    );

endmodule
